// File: rtl/clock_pkg.sv
// Shared types and limits for the clock time-setting controller.
// Field codes double as the core's mode encoding.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    EDIT_S
  } state_t;

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;

  localparam logic [7:0] HOUR_MAX   = 8'd23;
  localparam logic [7:0] MINSEC_MAX = 8'd59;

  function automatic logic [7:0] clamp_field(
    input logic [7:0] v,
    input logic [7:0] mx
  );
    return (v > mx) ? 8'd0 : v;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    logic [1:0] f;
    f = FIELD_SEC;
    unique case (s)
      EDIT_H:  f = FIELD_HOUR;
      EDIT_M:  f = FIELD_MIN;
      default: f = FIELD_SEC;
    endcase
    return f;
  endfunction

  function automatic state_t next_field(input state_t s);
    state_t n;
    n = IDLE;
    unique case (s)
      EDIT_H:  n = EDIT_M;
      EDIT_M:  n = EDIT_S;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Write port between the set controller and the clock core,
// plus the live time the core feeds back for preloading.
interface clock_set_ctrl_if;
  logic [1:0] mode;
  logic       wen;
  logic [7:0] wdata;
  logic [7:0] cur_hour;
  logic [7:0] cur_minute;
  logic [7:0] cur_second;

  modport master (
    output mode, wen, wdata,
    input  cur_hour, cur_minute, cur_second
  );

  modport slave (
    input  mode, wen, wdata,
    output cur_hour, cur_minute, cur_second
  );
endinterface

// File: rtl/field_stepper.sv
// Wrap-around +1/-1 of a time field bounded by 0..max_val.
// Both or neither step requests leave the value unchanged.
module field_stepper (
  input  logic [7:0] value,
  input  logic [7:0] max_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  always_comb begin
    result = value;
    unique case (1'b1)
      inc & ~dec:
        result = (value >= max_val) ? 8'd0 : value + 8'd1;
      dec & ~inc:
        result = (value == 8'd0) ? max_val : value - 8'd1;
      default: result = value;
    endcase
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Hour/minute/second edit FSM driving the clock core write port,
// with inactivity timeout and a blink strobe for the display.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 600,
  parameter int BLINK_HALF     = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_set,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_ok,
  input  logic [1:0]       disp_mode,
  clock_set_ctrl_if.master core,
  output logic [7:0]       edit_val,
  output logic             editing,
  output logic             blink
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] B_END = BW'(BLINK_HALF - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [7:0]    edit_q, edit_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [1:0]    mode_q, mode_d;
  logic          wen_q, wen_d;
  logic          blink_q, blink_d;
  logic          editing_q, editing_d;

  logic [7:0] cur_max;
  logic [7:0] stepped;
  logic       commit;
  logic       active;

  assign cur_max = (state_q == EDIT_H) ? HOUR_MAX : MINSEC_MAX;
  assign commit  = btn_ok | btn_set;
  assign active  = commit | btn_inc | btn_dec;

  field_stepper u_step (
    .value   (edit_q),
    .max_val (cur_max),
    .inc     (btn_inc),
    .dec     (btn_dec),
    .result  (stepped)
  );

  always_comb begin
    state_d   = state_q;
    edit_d    = edit_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    mode_d    = mode_q;
    tcnt_d    = '0;
    bcnt_d    = '0;
    blink_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        mode_d = disp_mode;
        if (btn_set) begin
          state_d = EDIT_H;
          edit_d  = clamp_field(core.cur_hour, HOUR_MAX);
          mode_d  = FIELD_HOUR;
          blink_d = 1'b1;
        end
      end
      default: begin
        if (commit) begin
          wen_d   = 1'b1;
          wdata_d = edit_q;
          state_d = next_field(state_q);
          unique case (state_q)
            EDIT_H:
              edit_d = clamp_field(core.cur_minute, MINSEC_MAX);
            EDIT_M:
              edit_d = clamp_field(core.cur_second, MINSEC_MAX);
            default: edit_d = edit_q;
          endcase
        end else if (active) begin
          edit_d = stepped;
        end else begin
          tcnt_d = (tcnt_q == T_END) ? tcnt_q : tcnt_q + TW'(1);
          if (tcnt_d == T_END) state_d = IDLE;
        end
        // the write cycle keeps the committed field's code on mode
        if (commit || state_d != IDLE) mode_d = field_of(state_q);
        else                           mode_d = disp_mode;
        if (state_d != IDLE) begin
          blink_d = blink_q;
          bcnt_d  = bcnt_q + BW'(1);
          if (bcnt_q == B_END) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end
        end
      end
    endcase
    editing_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      edit_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= '0;
      wen_q     <= 1'b0;
      blink_q   <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      edit_q    <= edit_d;
      wdata_q   <= wdata_d;
      mode_q    <= mode_d;
      wen_q     <= wen_d;
      blink_q   <= blink_d;
      editing_q <= editing_d;
    end
  end

  assign core.mode  = mode_q;
  assign core.wen   = wen_q;
  assign core.wdata = wdata_q;
  assign edit_val   = edit_q;
  assign editing    = editing_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed table plus randomized run against a field-level model
// of the time-setting controller.
module tb_clock_set_ctrl;

  localparam int TO = 8;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_ok = 1'b0;
  logic [1:0] disp_mode = 2'd0;
  logic [7:0] edit_val;
  logic       editing;
  logic       blink;

  always #5 clk = ~clk;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .BLINK_HALF     (BH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_set   (btn_set),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .btn_ok    (btn_ok),
    .disp_mode (disp_mode),
    .core      (bus.master),
    .edit_val  (edit_val),
    .editing   (editing),
    .blink     (blink)
  );

  typedef struct {
    bit         r, s, i, d, o;
    logic [1:0] dm;
    logic [7:0] h, m, sc;
    logic [1:0] e_mode;
    logic       e_wen;
    logic [7:0] e_wdata;
    logic [7:0] e_edit;
    logic       e_editing;
    logic       e_blink;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   miss = 0;

  // model: field index (-1 idle, 2 hour, 1 minute, 0 second)
  int         m_field = -1;
  int         m_idle = 0;
  int         m_age = 0;
  logic [7:0] m_val = 0;
  logic [7:0] m_wdata = 0;
  logic [1:0] e_mode = 0;
  logic       e_wen = 0;

  function automatic void add(
    input bit r, s, i, d, o,
    input logic [1:0] dm,
    input logic [7:0] h, m, sc,
    input logic [1:0] em,
    input logic ew,
    input logic [7:0] ewd, eed,
    input logic eedit, ebl
  );
    vec_t v;
    v.r = r; v.s = s; v.i = i; v.d = d; v.o = o;
    v.dm = dm; v.h = h; v.m = m; v.sc = sc;
    v.e_mode = em; v.e_wen = ew; v.e_wdata = ewd;
    v.e_edit = eed; v.e_editing = eedit; v.e_blink = ebl;
    tbl.push_back(v);
  endfunction

  task automatic model_step(
    input bit r, s, i, d, o,
    input logic [1:0] dm,
    input logic [7:0] h, m, sc
  );
    int mx;
    if (r) begin
      m_field = -1; m_idle = 0; m_age = 0;
      m_val = 0; m_wdata = 0; e_mode = 0; e_wen = 0;
      return;
    end
    e_wen = 0;
    if (m_field < 0) begin
      e_mode = dm;
      if (s) begin
        m_field = 2; m_idle = 0; m_age = 0;
        m_val = (h > 23) ? 8'd0 : h;
        e_mode = 2;
      end
    end else begin
      mx = (m_field == 2) ? 23 : 59;
      m_age++;
      if (s || o) begin
        e_wen = 1; m_wdata = m_val;
        e_mode = m_field[1:0];
        m_idle = 0;
        m_field--;
        if (m_field == 1) m_val = (m > 59) ? 8'd0 : m;
        else if (m_field == 0) m_val = (sc > 59) ? 8'd0 : sc;
      end else if (i || d) begin
        m_idle = 0;
        if (i && !d) m_val = 8'((m_val + 1) % (mx + 1));
        else if (d && !i) m_val = 8'((m_val + mx) % (mx + 1));
        e_mode = m_field[1:0];
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_field = -1;
          e_mode = dm;
        end else begin
          e_mode = m_field[1:0];
        end
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(
    input bit r, s, i, d, o,
    input logic [1:0] dm,
    input logic [7:0] h, m, sc
  );
    reset = r; btn_set = s; btn_inc = i; btn_dec = d; btn_ok = o;
    disp_mode = dm;
    bus.cur_hour = h; bus.cur_minute = m; bus.cur_second = sc;
    @(posedge clk);
    model_step(r, s, i, d, o, dm, h, m, sc);
    @(negedge clk);
    nvec++;
  endtask

  task automatic check_all(
    input string tag,
    input logic [1:0] em, input logic ew,
    input logic [7:0] ewd, eed,
    input logic eedit, ebl
  );
    cmp({tag, " mode"}, {6'd0, bus.mode}, {6'd0, em});
    cmp({tag, " wen"}, {7'd0, bus.wen}, {7'd0, ew});
    cmp({tag, " wdata"}, bus.wdata, ewd);
    cmp({tag, " edit_val"}, edit_val, eed);
    cmp({tag, " editing"}, {7'd0, editing}, {7'd0, eedit});
    cmp({tag, " blink"}, {7'd0, blink}, {7'd0, ebl});
  endtask

  initial begin
    bus.cur_hour = 0; bus.cur_minute = 0; bus.cur_second = 0;

    // reset, display passthrough, hour edit with wrap, minute edit
    add(1,0,0,0,0, 1, 22,0,30,  0,0, 0, 0,0,0);
    add(0,0,0,0,0, 1, 22,0,30,  1,0, 0, 0,0,0);
    add(0,1,0,0,0, 1, 22,0,30,  2,0, 0,22,1,1);
    add(0,0,1,0,0, 1, 22,0,30,  2,0, 0,23,1,1);
    add(0,0,1,0,0, 1, 22,0,30,  2,0, 0, 0,1,1);
    add(0,0,1,0,0, 1, 22,0,30,  2,0, 0, 1,1,1);
    add(0,0,0,0,1, 1, 22,0,30,  2,1, 1, 0,1,0);
    add(0,0,0,1,0, 1, 22,0,30,  1,0, 1,59,1,0);
    add(0,0,1,1,0, 1, 22,0,30,  1,0, 1,59,1,0);
    add(0,0,0,0,0, 1, 22,0,30,  1,0, 1,59,1,0);
    add(0,0,0,0,0, 1, 22,0,30,  1,0, 1,59,1,1);
    add(0,0,0,0,1, 1, 22,0,30,  1,1,59,30,1,1);
    add(0,1,0,0,0, 1, 22,0,30,  0,1,30,30,0,0);
    add(0,0,0,0,0, 3, 22,0,30,  3,0,30,30,0,0);

    // plain timeout, with out-of-range hour clamped on load
    add(0,1,0,0,0, 3, 30,0,30,  2,0,30, 0,1,1);
    for (int k = 1; k < 8; k++)
      add(0,0,0,0,0, 3, 30,0,30, 2,0,30,0,1, ((k / BH) % 2) == 0);
    add(0,0,0,0,0, 3, 30,0,30,  3,0,30, 0,0,0);

    // activity at cycle 6 restarts the timeout
    add(0,1,0,0,0, 3, 5,0,30,   2,0,30, 5,1,1);
    for (int k = 1; k < 6; k++)
      add(0,0,0,0,0, 3, 5,0,30, 2,0,30,5,1, ((k / BH) % 2) == 0);
    add(0,0,1,0,0, 3, 5,0,30,   2,0,30, 6,1,0);
    for (int k = 7; k < 14; k++)
      add(0,0,0,0,0, 3, 5,0,30, 2,0,30,6,1, ((k / BH) % 2) == 0);
    add(0,0,0,0,0, 3, 5,0,30,   3,0,30, 6,0,0);

    // reset while in EDIT_S overrides a simultaneous commit
    add(0,1,0,0,0, 1, 22,0,30,  2,0,30,22,1,1);
    add(0,0,0,0,1, 1, 22,0,30,  2,1,22, 0,1,1);
    add(0,0,0,0,1, 1, 22,0,30,  1,1, 0,30,1,1);
    add(1,0,0,0,1, 1, 22,0,30,  0,0, 0, 0,0,0);
    add(0,0,0,0,0, 2, 22,0,30,  2,0, 0, 0,0,0);

    @(negedge clk);
    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].s, tbl[k].i, tbl[k].d, tbl[k].o,
            tbl[k].dm, tbl[k].h, tbl[k].m, tbl[k].sc);
      check_all($sformatf("tbl%0d", k), tbl[k].e_mode, tbl[k].e_wen,
                tbl[k].e_wdata, tbl[k].e_edit,
                tbl[k].e_editing, tbl[k].e_blink);
    end

    apply(1,0,0,0,0, 0, 0,0,0);
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] h, m, sc;
      bit r, s, i, d, o;
      h  = 8'($urandom_range(0, 30));
      m  = 8'($urandom_range(0, 70));
      sc = 8'($urandom_range(0, 70));
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 14) == 0);
      i  = ($urandom_range(0, 5) == 0);
      d  = ($urandom_range(0, 6) == 0);
      o  = ($urandom_range(0, 12) == 0);
      apply(r, s, i, d, o, 2'($urandom_range(0, 3)), h, m, sc);
      check_all($sformatf("rnd%0d", n), e_mode, e_wen, m_wdata, m_val,
                m_field >= 0,
                (m_field >= 0) && (((m_age / BH) % 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end

endmodule
